// File: rtl/receptor_atualizacoes_pkg.sv
// Shared widths, FSM encodings and the active-table entry layout for the
// update receiver of the write-orderer -> active-evaluator handshake.
package receptor_atualizacoes_pkg;

    localparam int unsigned ADDR_WIDTH      = 10;
    localparam int unsigned DISTANCIA_WIDTH = 6;
    localparam int unsigned CUSTO_WIDTH     = 4;
    localparam int unsigned NUM_EA          = 8;
    localparam int unsigned DEPTH           = 16;
    localparam int unsigned DEPTH_WIDTH     = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH       = DEPTH_WIDTH + 1;
    localparam int unsigned SLOT_WIDTH      = $clog2(NUM_EA);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PROCESS = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Field order fixes the packed offsets: valid at the MSB, anterior at the LSBs.
    typedef struct packed {
        logic                       valid;
        logic [ADDR_WIDTH-1:0]      endereco;
        logic [CUSTO_WIDTH-1:0]     custo;
        logic [DISTANCIA_WIDTH-1:0] distancia;
        logic [ADDR_WIDTH-1:0]      anterior;
    } entrada_t;

endpackage

// File: rtl/receptor_atualizacoes_if.sv
// Update-command bus from the write orderer plus the busy/ready replies.
interface receptor_atualizacoes_if;
    import receptor_atualizacoes_pkg::*;

    logic                              oe_atualizar_in;
    logic [NUM_EA-1:0]                 oe_vizinho_valido_in;
    logic [ADDR_WIDTH*NUM_EA-1:0]      oe_endereco_in;
    logic [CUSTO_WIDTH*NUM_EA-1:0]     oe_menor_vizinho_in;
    logic [DISTANCIA_WIDTH*NUM_EA-1:0] oe_distancia_in;
    logic [ADDR_WIDTH-1:0]             oe_anterior_in;
    logic                              aa_ocupado_out;
    logic                              aa_atualizar_ready_out;

    modport master (
        output oe_atualizar_in, oe_vizinho_valido_in, oe_endereco_in,
               oe_menor_vizinho_in, oe_distancia_in, oe_anterior_in,
        input  aa_ocupado_out, aa_atualizar_ready_out
    );

    modport slave (
        input  oe_atualizar_in, oe_vizinho_valido_in, oe_endereco_in,
               oe_menor_vizinho_in, oe_distancia_in, oe_anterior_in,
        output aa_ocupado_out, aa_atualizar_ready_out
    );

endinterface

// File: rtl/receptor_atualizacoes_seletor_menor_custo.sv
// Combinational minimum-cost search over the active table; on equal cost the
// lowest table index wins.
module receptor_atualizacoes_seletor_menor_custo
    import receptor_atualizacoes_pkg::*;
(
    input  logic [DEPTH-1:0]                  valido,
    input  logic [DEPTH-1:0][CUSTO_WIDTH-1:0] custo,
    output logic [DEPTH_WIDTH-1:0]            idx_c,
    output logic                              found_c
);

    logic [CUSTO_WIDTH-1:0] best_c;

    // Strict less-than keeps the earlier index on ties.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        best_c  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valido[i] && (!found_c || (custo[i] < best_c))) begin
                found_c = 1'b1;
                idx_c   = DEPTH_WIDTH'(i);
                best_c  = custo[i];
            end
        end
    end

endmodule

// File: rtl/receptor_atualizacoes.sv
// Receives neighbour-update commands, merges them slot by slot into the
// active-node table and offers the cheapest active node on a pop port.
module receptor_atualizacoes
    import receptor_atualizacoes_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    receptor_atualizacoes_if.slave     oe_if,
    output logic                       sel_valid_out,
    input  logic                       sel_ready_in,
    output logic [ADDR_WIDTH-1:0]      sel_endereco_out,
    output logic [CUSTO_WIDTH-1:0]     sel_custo_out,
    output logic [DISTANCIA_WIDTH-1:0] sel_distancia_out,
    output logic [ADDR_WIDTH-1:0]      sel_anterior_out,
    output logic [CNT_WIDTH-1:0]       ativos_count_out,
    output logic                       overflow_out
);

    logic [1:0]                        state, state_nxt;
    logic [SLOT_WIDTH-1:0]             slot_k;
    entrada_t                          tabela [DEPTH];

    logic [NUM_EA-1:0]                 cmd_valido;
    logic [ADDR_WIDTH*NUM_EA-1:0]      cmd_endereco;
    logic [CUSTO_WIDTH*NUM_EA-1:0]     cmd_custo;
    logic [DISTANCIA_WIDTH*NUM_EA-1:0] cmd_distancia;
    logic [ADDR_WIDTH-1:0]             cmd_anterior;
    logic [DEPTH_WIDTH-1:0]            sel_idx_r;

    logic                              slot_valido_c;
    logic [ADDR_WIDTH-1:0]             slot_endereco_c;
    logic [CUSTO_WIDTH-1:0]            slot_custo_c;
    logic [DISTANCIA_WIDTH-1:0]        slot_distancia_c;
    logic                              hit_c, free_c;
    logic [DEPTH_WIDTH-1:0]            hit_idx_c, free_idx_c;
    logic                              upd_c, ins_c, drop_c, pop_c, last_slot_c;
    logic [DEPTH-1:0]                  min_valido_c;
    logic [DEPTH-1:0][CUSTO_WIDTH-1:0] min_custo_c;
    logic [DEPTH_WIDTH-1:0]            min_idx_c;
    logic                              min_found_c;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (oe_if.oe_atualizar_in) state_nxt = ST_PROCESS;
            ST_PROCESS: if (last_slot_c) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Slot counter runs only in PROCESS and is parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst)                     slot_k <= '0;
        else if (state == ST_PROCESS) slot_k <= slot_k + SLOT_WIDTH'(1);
        else                         slot_k <= '0;
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && oe_if.oe_atualizar_in) begin
            cmd_valido    <= oe_if.oe_vizinho_valido_in;
            cmd_endereco  <= oe_if.oe_endereco_in;
            cmd_custo     <= oe_if.oe_menor_vizinho_in;
            cmd_distancia <= oe_if.oe_distancia_in;
            cmd_anterior  <= oe_if.oe_anterior_in;
        end
    end

    assign last_slot_c      = (slot_k == SLOT_WIDTH'(NUM_EA - 1));
    assign slot_valido_c    = cmd_valido[slot_k];
    assign slot_endereco_c  = cmd_endereco[int'(slot_k)*ADDR_WIDTH +: ADDR_WIDTH];
    assign slot_custo_c     = cmd_custo[int'(slot_k)*CUSTO_WIDTH +: CUSTO_WIDTH];
    assign slot_distancia_c = cmd_distancia[int'(slot_k)*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];

    // Parallel address match and lowest free-entry search for the current slot.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!hit_c && tabela[i].valid && (tabela[i].endereco == slot_endereco_c)) begin
                hit_c     = 1'b1;
                hit_idx_c = DEPTH_WIDTH'(i);
            end
            if (!free_c && !tabela[i].valid) begin
                free_c     = 1'b1;
                free_idx_c = DEPTH_WIDTH'(i);
            end
        end
    end

    assign upd_c  = (state == ST_PROCESS) && slot_valido_c && hit_c &&
                    (slot_custo_c < tabela[hit_idx_c].custo);
    assign ins_c  = (state == ST_PROCESS) && slot_valido_c && !hit_c && free_c;
    assign drop_c = (state == ST_PROCESS) && slot_valido_c && !hit_c && !free_c;
    assign pop_c  = (state == ST_IDLE) && sel_valid_out && sel_ready_in;

    // The entry being popped is hidden so the next selection is already post-pop.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            min_valido_c[i] = tabela[i].valid && !(pop_c && (sel_idx_r == DEPTH_WIDTH'(i)));
            min_custo_c[i]  = tabela[i].custo;
        end
    end

    receptor_atualizacoes_seletor_menor_custo u_seletor_menor_custo (
        .valido  (min_valido_c),
        .custo   (min_custo_c),
        .idx_c   (min_idx_c),
        .found_c (min_found_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) tabela[i].valid <= 1'b0;
        end else begin
            if (pop_c) tabela[sel_idx_r].valid <= 1'b0;
            if (upd_c) begin
                tabela[hit_idx_c].custo     <= slot_custo_c;
                tabela[hit_idx_c].distancia <= slot_distancia_c;
                tabela[hit_idx_c].anterior  <= cmd_anterior;
            end
            if (ins_c) begin
                tabela[free_idx_c] <= '{valid: 1'b1, endereco: slot_endereco_c,
                                        custo: slot_custo_c, distancia: slot_distancia_c,
                                        anterior: cmd_anterior};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_if.aa_ocupado_out         <= 1'b0;
            oe_if.aa_atualizar_ready_out <= 1'b0;
            overflow_out                 <= 1'b0;
            ativos_count_out             <= '0;
            sel_valid_out                <= 1'b0;
            sel_idx_r                    <= '0;
            sel_endereco_out             <= '0;
            sel_custo_out                <= '0;
            sel_distancia_out            <= '0;
            sel_anterior_out             <= '0;
        end else begin
            oe_if.aa_ocupado_out         <= (state_nxt == ST_PROCESS);
            oe_if.aa_atualizar_ready_out <= (state_nxt == ST_DONE);
            overflow_out                 <= overflow_out | drop_c;
            ativos_count_out             <= ativos_count_out + CNT_WIDTH'(ins_c) - CNT_WIDTH'(pop_c);
            sel_valid_out                <= (state_nxt == ST_IDLE) && min_found_c;
            if ((state_nxt == ST_IDLE) && min_found_c) begin
                sel_idx_r         <= min_idx_c;
                sel_endereco_out  <= tabela[min_idx_c].endereco;
                sel_custo_out     <= tabela[min_idx_c].custo;
                sel_distancia_out <= tabela[min_idx_c].distancia;
                sel_anterior_out  <= tabela[min_idx_c].anterior;
            end
        end
    end

endmodule

// File: tb/tb_receptor_atualizacoes.sv
// Directed bench for receptor_atualizacoes with a queue of expected pop results.
module tb_receptor_atualizacoes;
    import receptor_atualizacoes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic sel_valid_out, sel_ready_in, overflow_out;
    logic [ADDR_WIDTH-1:0]      sel_endereco_out, sel_anterior_out;
    logic [CUSTO_WIDTH-1:0]     sel_custo_out;
    logic [DISTANCIA_WIDTH-1:0] sel_distancia_out;
    logic [CNT_WIDTH-1:0]       ativos_count_out;

    receptor_atualizacoes_if oe_if ();

    receptor_atualizacoes dut (
        .clk               (clk),
        .rst               (rst),
        .oe_if             (oe_if),
        .sel_valid_out     (sel_valid_out),
        .sel_ready_in      (sel_ready_in),
        .sel_endereco_out  (sel_endereco_out),
        .sel_custo_out     (sel_custo_out),
        .sel_distancia_out (sel_distancia_out),
        .sel_anterior_out  (sel_anterior_out),
        .ativos_count_out  (ativos_count_out),
        .overflow_out      (overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        int unsigned c;
        int unsigned d;
        int unsigned p;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [NUM_EA-1:0]                 v_mask;
    logic [ADDR_WIDTH*NUM_EA-1:0]      v_end;
    logic [CUSTO_WIDTH*NUM_EA-1:0]     v_custo;
    logic [DISTANCIA_WIDTH*NUM_EA-1:0] v_dist;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr_slots();
        v_mask = '0; v_end = '0; v_custo = '0; v_dist = '0;
    endtask

    task automatic put_slot(input int k, input int unsigned a, input int unsigned c, input int unsigned d);
        v_mask[k] = 1'b1;
        v_end[k*ADDR_WIDTH +: ADDR_WIDTH]              = ADDR_WIDTH'(a);
        v_custo[k*CUSTO_WIDTH +: CUSTO_WIDTH]          = CUSTO_WIDTH'(c);
        v_dist[k*DISTANCIA_WIDTH +: DISTANCIA_WIDTH]   = DISTANCIA_WIDTH'(d);
    endtask

    task automatic drive_cmd(input int unsigned ant, input logic pop);
        oe_if.oe_vizinho_valido_in = v_mask;
        oe_if.oe_endereco_in       = v_end;
        oe_if.oe_menor_vizinho_in  = v_custo;
        oe_if.oe_distancia_in      = v_dist;
        oe_if.oe_anterior_in       = ADDR_WIDTH'(ant);
        oe_if.oe_atualizar_in      = 1'b1;
        sel_ready_in               = pop;
        tick();
        oe_if.oe_atualizar_in      = 1'b0;
        sel_ready_in               = 1'b0;
    endtask

    // Issue a command and check busy, fixed latency and one-cycle ready pulse.
    task automatic run_cmd(input string tag, input int unsigned ant, input logic pop);
        int lat;
        drive_cmd(ant, pop);
        chk({tag, "_busy"}, int'(oe_if.aa_ocupado_out), 1);
        lat = 1;
        while (!oe_if.aa_atualizar_ready_out && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 9);
        tick();
        chk({tag, "_ready_pulse"}, int'(oe_if.aa_atualizar_ready_out), 0);
        chk({tag, "_idle_busy"}, int'(oe_if.aa_ocupado_out), 0);
    endtask

    task automatic expect_sel(input int unsigned a, input int unsigned c, input int unsigned d, input int unsigned p);
        exp_t e;
        e.a = a; e.c = c; e.d = d; e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic cmp_sel(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, int'(sel_valid_out), 1);
        chk({tag, "_addr"},  int'(sel_endereco_out), e.a);
        chk({tag, "_cost"},  int'(sel_custo_out), e.c);
        chk({tag, "_dist"},  int'(sel_distancia_out), e.d);
        chk({tag, "_ant"},   int'(sel_anterior_out), e.p);
    endtask

    task automatic pop_sel(input string tag);
        cmp_sel(tag);
        sel_ready_in = 1'b1;
        tick();
        sel_ready_in = 1'b0;
    endtask

    initial begin
        int unsigned fc [DEPTH];
        logic seen_ready;
        rst = 1'b1;
        sel_ready_in = 1'b0;
        oe_if.oe_atualizar_in = 1'b0;
        clr_slots();
        drive_cmd(0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rst_busy",     int'(oe_if.aa_ocupado_out), 0);
        chk("rst_ready",    int'(oe_if.aa_atualizar_ready_out), 0);
        chk("rst_selvalid", int'(sel_valid_out), 0);
        chk("rst_count",    int'(ativos_count_out), 0);
        chk("rst_overflow", int'(overflow_out), 0);
        chk("rst_seladdr",  int'(sel_endereco_out), 0);

        // Two valid slots out of eight.
        clr_slots();
        put_slot(0, 5, 3, 10);
        put_slot(2, 9, 1, 20);
        run_cmd("t1", 2, 1'b0);
        chk("t1_count", int'(ativos_count_out), 2);
        expect_sel(9, 1, 20, 2);
        cmp_sel("t1_sel");

        // Strictly lower cost updates; equal and higher costs are discarded.
        clr_slots(); put_slot(0, 5, 2, 11);
        run_cmd("t2a", 3, 1'b0);
        clr_slots(); put_slot(0, 5, 2, 12);
        run_cmd("t2b", 7, 1'b0);
        clr_slots(); put_slot(0, 5, 7, 13);
        run_cmd("t2c", 8, 1'b0);
        chk("t2_count", int'(ativos_count_out), 2);
        expect_sel(9, 1, 20, 2);
        expect_sel(5, 2, 11, 3);
        pop_sel("t2_pop0");
        pop_sel("t2_pop1");
        chk("t2_empty", int'(sel_valid_out), 0);
        chk("t2_count0", int'(ativos_count_out), 0);

        // Fill all sixteen entries with a cost permutation.
        for (int i = 0; i < int'(DEPTH); i++) fc[i] = (i * 7 + 3) % 16;
        clr_slots();
        for (int k = 0; k < int'(NUM_EA); k++) put_slot(k, 100 + k, fc[k], k);
        run_cmd("fillA", 50, 1'b0);
        clr_slots();
        for (int k = 0; k < int'(NUM_EA); k++) put_slot(k, 108 + k, fc[k + 8], k + 8);
        run_cmd("fillB", 51, 1'b0);
        chk("fill_count", int'(ativos_count_out), 16);
        chk("fill_ovf", int'(overflow_out), 0);

        // Pop and strobe together on a full table: the freed slot takes the insert.
        expect_sel(111, 0, 11, 51);
        cmp_sel("popins_before");
        clr_slots(); put_slot(0, 300, 9, 33);
        run_cmd("popins", 52, 1'b1);
        chk("popins_count", int'(ativos_count_out), 16);
        chk("popins_ovf", int'(overflow_out), 0);
        expect_sel(102, 1, 2, 50);
        cmp_sel("popins_sel");

        // New address on a full table is dropped and overflow sticks.
        clr_slots(); put_slot(0, 400, 0, 1);
        run_cmd("ovf", 53, 1'b0);
        chk("ovf_flag", int'(overflow_out), 1);
        chk("ovf_count", int'(ativos_count_out), 16);
        expect_sel(102, 1, 2, 50);
        pop_sel("ovf_pop");
        chk("ovf_sticky", int'(overflow_out), 1);
        chk("ovf_count_pop", int'(ativos_count_out), 15);
        expect_sel(109, 2, 9, 51);
        cmp_sel("ovf_next");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_count", int'(ativos_count_out), 0);
        chk("rst2_ovf", int'(overflow_out), 0);
        chk("rst2_selvalid", int'(sel_valid_out), 0);

        // Pop order on costs {4,1,1,6}: ties go to the lower index.
        clr_slots();
        put_slot(0, 20, 4, 1);
        put_slot(1, 21, 1, 2);
        put_slot(2, 22, 1, 3);
        put_slot(3, 23, 6, 4);
        run_cmd("order", 5, 1'b0);
        chk("order_count", int'(ativos_count_out), 4);
        expect_sel(21, 1, 2, 5);
        expect_sel(22, 1, 3, 5);
        expect_sel(20, 4, 1, 5);
        expect_sel(23, 6, 4, 5);
        pop_sel("order_p0");
        pop_sel("order_p1");
        pop_sel("order_p2");
        pop_sel("order_p3");
        chk("order_empty", int'(sel_valid_out), 0);
        chk("order_count0", int'(ativos_count_out), 0);

        // Reset while slot 3 is being processed aborts the command.
        clr_slots();
        for (int k = 0; k < int'(NUM_EA); k++) put_slot(k, 60 + k, k, k);
        drive_cmd(9, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",  int'(oe_if.aa_ocupado_out), 0);
        chk("abort_count", int'(ativos_count_out), 0);
        seen_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen_ready = seen_ready | oe_if.aa_atualizar_ready_out;
            tick();
        end
        chk("abort_no_ready", int'(seen_ready), 0);
        chk("abort_selvalid", int'(sel_valid_out), 0);
        clr_slots(); put_slot(0, 70, 5, 6);
        run_cmd("after", 4, 1'b0);
        chk("after_count", int'(ativos_count_out), 1);
        expect_sel(70, 5, 6, 4);
        cmp_sel("after_sel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/receptor_atualizacoes.md
Name: receptor_atualizacoes

Overview:
- Responder side of the write-orderer → active-evaluator update handshake.
- Accepts one update command carrying up to NUM_EA neighbour slots and merges each valid slot into an internal active-node table of DEPTH entries. A slot either inserts a new node, or replaces an existing node when its cost is strictly lower.
- Presents the minimum-cost active node to the downstream expansion stage through a valid/ready pop port.
- Drives aa_ocupado and aa_atualizar_ready back to the orderer.

Parameters:
- ADDR_WIDTH, 10, node address width
- DISTANCIA_WIDTH, 6, distance field width
- CUSTO_WIDTH, 4, cost field width
- NUM_EA, 8, neighbour slots per update command
- DEPTH, 16, active-table entries
- DEPTH_WIDTH, 4, log2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- oe_atualizar_in  in  1  update-command strobe
- oe_vizinho_valido_in  in  NUM_EA  slot-valid mask
- oe_endereco_in  in  ADDR_WIDTH*NUM_EA  slot node addresses; slot k at [ADDR_WIDTH*k +: ADDR_WIDTH]
- oe_menor_vizinho_in  in  CUSTO_WIDTH*NUM_EA  slot costs
- oe_distancia_in  in  DISTANCIA_WIDTH*NUM_EA  slot distances
- oe_anterior_in  in  ADDR_WIDTH  predecessor shared by all slots
- aa_ocupado_out  out  1  command in progress
- aa_atualizar_ready_out  out  1  one-cycle completion pulse
- sel_valid_out  out  1  minimum entry available
- sel_ready_in  in  1  consumer pops minimum entry
- sel_endereco_out  out  ADDR_WIDTH  minimum entry address
- sel_custo_out  out  CUSTO_WIDTH  minimum entry cost
- sel_distancia_out  out  DISTANCIA_WIDTH  minimum entry distance
- sel_anterior_out  out  ADDR_WIDTH  minimum entry predecessor
- ativos_count_out  out  DEPTH_WIDTH+1  number of valid entries
- overflow_out  out  1  sticky flag: a slot was dropped because the table was full

Behaviour:
- Reset (rst=1 at a clock edge):
  - all table valid bits cleared; state IDLE
  - aa_ocupado_out=0, aa_atualizar_ready_out=0, sel_valid_out=0, ativos_count_out=0, overflow_out=0
  - all sel_* data outputs=0
  - reset mid-command aborts the command; no ready pulse is issued
- FSM states: IDLE, PROCESS, DONE.
  - IDLE: if oe_atualizar_in=1 at cycle T, register all inputs, set slot index k=0, go to PROCESS.
  - PROCESS: handles slot k in cycle T+1+k. After k=NUM_EA-1, go to DONE.
  - DONE: assert aa_atualizar_ready_out for exactly one cycle (T+NUM_EA+1), then return to IDLE.
  - Command latency is fixed at NUM_EA+1 cycles regardless of the valid mask; invalid slots consume their cycle with no table change.
- aa_ocupado_out is registered; high during cycles T+1..T+NUM_EA, low from DONE onward.
- oe_atualizar_in outside IDLE is ignored; the orderer guarantees it does not occur.
- Slot processing, only when the slot is valid:
  - All DEPTH entries are address-compared in parallel.
  - Hit, and new cost < stored cost: overwrite custo, distancia and anterior of the hit entry.
  - Hit, and new cost >= stored cost: discard the slot; equal cost keeps the existing entry.
  - Miss: write the slot into the lowest-index free entry.
  - Miss with table full: drop the slot and set overflow_out=1 (sticky).
- Duplicate addresses within one command resolve naturally because slots are processed sequentially in order 0..NUM_EA-1.
- Selection:
  - In IDLE, sel_* are registered from a combinational minimum over the valid entries.
  - Tie on cost: lowest table index wins.
  - sel_valid_out=0 when the table is empty or the state is not IDLE.
- Pop:
  - When sel_valid_out=1 and sel_ready_in=1, invalidate the selected entry at that edge.
  - sel_* update the following cycle.
  - Pop is ignored outside IDLE.
- Pop and oe_atualizar_in in the same IDLE cycle: both take effect. The pop invalidation precedes the slot-0 processing.
- ativos_count_out: registered; tracks inserts minus pops; never exceeds DEPTH.
- Arithmetic: cost comparison is unsigned at CUSTO_WIDTH; no arithmetic on distancia, which is stored as-is.

Decomposition:
- Shared header/package:
  - FSM state encodings (IDLE/PROCESS/DONE)
  - table entry field widths and offsets (valid, endereco, custo, distancia, anterior)
  - the DEPTH_WIDTH derivation
- Sub-module seletor_menor_custo: combinational min tree over DEPTH entries with lowest-index tie-break. Outputs the selected index and a found flag.

Test Plan:
- Single command, mask=8'b0000_0101, slot0 addr=5 cost=3, slot2 addr=9 cost=1, anterior=2 -> ready pulses exactly 9 cycles after the strobe; count=2; sel shows addr 9, cost 1, anterior 2.
- Second command with addr=5 cost=2 -> entry 5 updated to cost 2; then addr=5 cost=2 again -> unchanged; then addr=5 cost=7 -> unchanged; count stays 2.
- Fill 16 distinct addresses, then send one more new address -> slot dropped; overflow_out=1 and stays 1 after popping; count=16 before the pop.
- Pop sequence on costs {4,1,1,6} at indices 0..3 -> pops return index1, index2, index0, index3; sel_valid_out=0 after the fourth pop.
- Strobe and pop in the same IDLE cycle with the table full -> the pop frees an entry, the new slot inserts into it, no overflow.
- rst asserted at PROCESS slot 3 -> no ready pulse; count=0; aa_ocupado_out=0 in the next cycle; a subsequent command completes normally.
